axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter ID_I, default 4'h0, arid/rid value for instruction-side transactions.
REQ-002 Parameter ID_D, default 4'h1, arid/rid value for data-side transactions.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  instruction-side read request; held until i_gnt.
REQ-006 i_addr  in  32  instruction request address.
REQ-007 i_len  in  4  instruction burst length minus one.
REQ-008 i_gnt  out  1  one-cycle pulse, request accepted.
REQ-009 i_rvalid / i_rlast  out  1 / 1  instruction beat valid / final beat.
REQ-010 d_req, d_addr, d_len  in  1, 32, 4  data-side request, as the instruction side.
REQ-011 d_size  in  3  data-side AXI size code.
REQ-012 d_gnt, d_rvalid, d_rlast  out  1, 1, 1  data-side equivalents.
REQ-013 rdata_o  out  32  beat data, broadcast to both clients; equals rdata.
REQ-014 arid, araddr, arlen, arsize, arburst, arvalid  out  4, 32, 4, 3, 2, 1  AXI AR channel.
REQ-015 arready  in  1  AXI AR handshake.
REQ-016 rid, rdata, rresp, rlast, rvalid  in  4, 32, 2, 1, 1  AXI R channel.
REQ-017 rready  out  1  AXI R handshake.

Function
REQ-018 FSM states IDLE, ADDR, DATA; exactly one read transaction outstanding at any time.
REQ-019 IDLE: on an edge where any req=1, latch the winner's addr, len and size (inst size fixed 3'b010) plus owner; next state ADDR.
REQ-020 Winner selection: single requester wins; on simultaneous requests, the side not granted last wins; last-grant flag resets to I, so D wins the first tie.
REQ-021 x_gnt=1 for exactly the first cycle of ADDR, for the owner only; client deasserts req after gnt; latched fields are unaffected by later input changes.
REQ-022 ADDR: arvalid=1; araddr, arlen, arsize and arid (ID_I or ID_D) driven from latches, stable until arready; arburst=2'b01 always.
REQ-023 ADDR with arready=1: next state DATA; arvalid=0 from the next cycle.
REQ-024 DATA: rready=1; x_rvalid = rvalid & (rid==owner ID) for the owner only; x_rlast = x_rvalid & rlast; rvalid, rid and rlast pass combinationally to the owner outputs with zero latency.
REQ-025 Beats with rid mismatching the owner are accepted (rready=1) and discarded; no client output is asserted for them.
REQ-026 DATA with a matching beat where rlast=1: next state IDLE; a new grant is possible on the following edge, giving a minimum 1 idle cycle between transactions.
REQ-027 rresp is ignored; error beats are forwarded like OKAY beats.
REQ-028 In IDLE and ADDR, rready=0 and both x_rvalid=0; outside ADDR, arvalid=0.
REQ-029 Burst length is not checked; rlast alone terminates DATA.

Reset
REQ-030 rst=1 at an edge forces IDLE, last-grant flag=I and all latches to 0, regardless of the current state.
REQ-031 During and after reset: arvalid=0, rready=0, i_gnt=d_gnt=0, i_rvalid=d_rvalid=0; araddr, arlen, arsize and arid read 0.
REQ-032 Reset mid-ADDR or mid-DATA abandons the transaction; no grant or beat is produced for it after reset.

Verification
REQ-033 i_req=1, i_addr=32'h1FC00000, i_len=4'd3, arready=1 immediately, then 4 beats rid=ID_I -> i_gnt pulse; araddr=32'h1FC00000, arlen=3, arsize=2, arid=0; i_rvalid x4 with i_rlast on the 4th; back to IDLE.
REQ-034 i_req and d_req high together from reset -> D granted first (arid=1, arsize=d_size); after D completes, I granted next without starvation.
REQ-035 arready held low 5 cycles in ADDR -> arvalid and all AR fields stable for 6 cycles; no R beats are forwarded.
REQ-036 rvalid beat with rid=4'h5 during a D transaction -> rready=1, d_rvalid=0, i_rvalid=0; a later matching beat with rlast=1 completes the transaction.
REQ-037 rst asserted for 1 cycle after the 2nd of 4 data beats -> next cycle IDLE, rready=0; the remaining beats produce no rvalid; a fresh request afterwards is granted normally.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// AXI4 read-address / read-data channel bundle between the arbiter (master)
// and the memory side (slave).
interface axi_read_arbiter_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-client (instruction / data) AXI read arbiter, one transaction in flight,
// alternating priority on simultaneous requests.
module axi_read_arbiter #(
   parameter logic [3:0] ID_I = 4'h0,
   parameter logic [3:0] ID_D = 4'h1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [31:0]         i_addr,
   input  logic [3:0]          i_len,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic                i_rlast,
   input  logic                d_req,
   input  logic [31:0]         d_addr,
   input  logic [3:0]          d_len,
   input  logic [2:0]          d_size,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic                d_rlast,
   output logic [31:0]         rdata_o,
   axi_read_arbiter_if.master  axi
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

   state_e      state_q, state_d;
   logic        last_d_q, last_d_d;   // last grant went to the data side
   logic        own_d_q, own_d_d;     // current owner is the data side
   logic        first_q, first_d;     // first cycle of ADDR
   logic [3:0]  id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  len_q, len_d;
   logic [2:0]  size_q, size_d;
   logic        win_d;
   logic        match;
   logic        unused_rresp;

   // Data side wins when alone, or on a tie when instruction side was granted last.
   assign win_d        = d_req & (~i_req | ~last_d_q);
   assign match        = (state_q == DATA) & axi.rvalid & (axi.rid == id_q);
   assign unused_rresp = ^axi.rresp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         own_d_q  <= 1'b0;
         first_q  <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         own_d_q  <= own_d_d;
         first_q  <= first_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      own_d_d  = own_d_q;
      first_d  = 1'b0;
      id_d     = id_q;
      addr_d   = addr_q;
      len_d    = len_q;
      size_d   = size_q;
      case (state_q)
         IDLE: begin
            if (i_req | d_req) begin
               state_d  = ADDR;
               first_d  = 1'b1;
               own_d_d  = win_d;
               last_d_d = win_d;
               id_d     = win_d ? ID_D   : ID_I;
               addr_d   = win_d ? d_addr : i_addr;
               len_d    = win_d ? d_len  : i_len;
               size_d   = win_d ? d_size : 3'b010;
            end
         end
         ADDR: if (axi.arready) state_d = DATA;
         DATA: if (match && axi.rlast) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign axi.arvalid = (state_q == ADDR);
   assign axi.arid    = id_q;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = len_q;
   assign axi.arsize  = size_q;
   assign axi.arburst = 2'b01;
   assign axi.rready  = (state_q == DATA);

   assign i_gnt    = first_q & ~own_d_q;
   assign d_gnt    = first_q &  own_d_q;
   assign i_rvalid = match & ~own_d_q;
   assign d_rvalid = match &  own_d_q;
   assign i_rlast  = i_rvalid & axi.rlast;
   assign d_rlast  = d_rvalid & axi.rlast;
   assign rdata_o  = axi.rdata;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized transaction-level bench for axi_read_arbiter: a small model tracks
// the tie-break owner and expected AR fields; beats are checked every cycle.
module tb_axi_read_arbiter;
   localparam logic [3:0] ID_I = 4'h0;
   localparam logic [3:0] ID_D = 4'h1;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req;
   logic [31:0] i_addr, d_addr;
   logic [3:0]  i_len, d_len;
   logic [2:0]  d_size;
   logic        i_gnt, i_rvalid, i_rlast, d_gnt, d_rvalid, d_rlast;
   logic [31:0] rdata_o;

   int n_run  = 0;
   int n_fail = 0;
   bit m_last_d;   // model: last grant went to data side

   axi_read_arbiter_if ax ();

   axi_read_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
      .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
      .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
      .rdata_o(rdata_o),
      .axi(ax)
   );

   always #5 clk = ~clk;

   wire [7:0]  ctl = {i_gnt, d_gnt, ax.arvalid, ax.rready, i_rvalid, d_rvalid, i_rlast, d_rlast};
   wire [44:0] ar  = {ax.arid, ax.araddr, ax.arlen, ax.arsize, ax.arburst};

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_req = 1'b1; d_req = 1'b1; i_addr = $urandom; d_addr = $urandom;
      ax.arready = 1'b1; ax.rvalid = 1'b1; ax.rid = ID_D; ax.rlast = 1'b1;
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         @(negedge clk);
         n_run++;
         if (ctl !== 8'h00) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 8'h00); end
         n_run++;
         if (ar !== 45'd1) begin n_fail++; $display("FAIL reset_ar: got %h want %h", ar, 45'd1); end
      end
      next_cycle();
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; ax.rvalid = 1'b0; ax.arready = 1'b0;
      m_last_d = 1'b0;
      @(negedge clk);
      n_run++;
      if (ctl !== 8'h00) begin n_fail++; $display("FAIL post_reset_ctl: got %b want %b", ctl, 8'h00); end
      next_cycle();
   endtask

   // One full read transaction; skip_idle means a pending loser request was
   // already latched during the previous transaction's trailing idle cycle.
   task automatic run_txn(input bit ireq, input bit dreq, input bit rnd, input bit skip_idle,
                          input int ar_dly, input int nbeats, input int abort_at);
      bit          win_d, done, exp_v;
      logic [44:0] ear;
      logic [3:0]  eid, jr;
      int          beats, cyc, kind;
      if (!skip_idle) begin
         if (ireq) begin i_req = 1'b1; if (rnd) begin i_addr = $urandom; i_len = 4'($urandom); end end
         if (dreq) begin
            d_req = 1'b1;
            if (rnd) begin d_addr = $urandom; d_len = 4'($urandom); d_size = 3'($urandom); end
         end
      end
      win_d    = (i_req && d_req) ? !m_last_d : d_req;
      m_last_d = win_d;
      eid      = win_d ? ID_D : ID_I;
      ear      = win_d ? {ID_D, d_addr, d_len, d_size, 2'b01} : {ID_I, i_addr, i_len, 3'b010, 2'b01};
      ax.rvalid = 1'b0; ax.arready = 1'b0;
      if (!skip_idle) begin
         @(negedge clk);
         n_run++;
         if (ctl !== 8'h00) begin n_fail++; $display("FAIL idle_ctl: got %b want %b", ctl, 8'h00); end
         next_cycle();
      end
      for (int c = 0; c <= ar_dly; c++) begin
         ax.arready = (c == ar_dly);
         ax.rvalid  = 1'($urandom_range(0, 1)); ax.rid = eid; ax.rlast = 1'b1;
         @(negedge clk);
         n_run++;
         if (ctl !== {c == 0 && !win_d, c == 0 && win_d, 6'b100000}) begin
            n_fail++; $display("FAIL addr_ctl c=%0d: got %b want %b", c, ctl, {c == 0 && !win_d, c == 0 && win_d, 6'b100000});
         end
         n_run++;
         if (ar !== ear) begin n_fail++; $display("FAIL addr_ar c=%0d: got %h want %h", c, ar, ear); end
         if (c == 0) begin
            if (win_d) begin d_req = 1'b0; d_addr = $urandom; d_len = 4'($urandom); d_size = 3'($urandom); end
            else       begin i_req = 1'b0; i_addr = $urandom; i_len = 4'($urandom); end
         end
         next_cycle();
      end
      ax.arready = 1'b0;
      beats = 0; done = 1'b0; cyc = 0;
      while (!done) begin
         kind = $urandom_range(0, 3);
         ax.rdata = $urandom; ax.rresp = 2'($urandom);
         if (kind == 0) begin
            ax.rvalid = 1'b0; ax.rid = eid; ax.rlast = 1'b1;
         end else if (kind == 1) begin
            jr = $urandom_range(0, 1) ? 4'h5 : (win_d ? ID_I : ID_D);
            ax.rvalid = 1'b1; ax.rid = jr; ax.rlast = 1'($urandom_range(0, 1));
         end else begin
            ax.rvalid = 1'b1; ax.rid = eid; ax.rlast = (beats == nbeats - 1);
         end
         exp_v = (kind >= 2);
         @(negedge clk);
         n_run++;
         if (ctl !== {3'b000, 1'b1, exp_v && !win_d, exp_v && win_d,
                      exp_v && !win_d && ax.rlast, exp_v && win_d && ax.rlast}) begin
            n_fail++; $display("FAIL data_ctl beat=%0d kind=%0d: got %b want %b", beats, kind, ctl,
               {3'b000, 1'b1, exp_v && !win_d, exp_v && win_d, exp_v && !win_d && ax.rlast, exp_v && win_d && ax.rlast});
         end
         n_run++;
         if (rdata_o !== ax.rdata) begin n_fail++; $display("FAIL rdata: got %h want %h", rdata_o, ax.rdata); end
         if (exp_v) beats++;
         if (exp_v && ax.rlast) done = 1'b1;
         if (abort_at != 0 && exp_v && beats == abort_at) begin rst = 1'b1; m_last_d = 1'b0; done = 1'b1; end
         cyc++;
         if (!done && cyc > 200) begin n_fail++; $display("FAIL data_timeout: got %0d beats want %0d", beats, nbeats); done = 1'b1; end
         next_cycle();
      end
      if (rst) begin
         rst = 1'b0;
         for (int c = 0; c < 3; c++) begin
            ax.rvalid = 1'b1; ax.rid = eid; ax.rlast = (c == 2); ax.rdata = $urandom;
            @(negedge clk);
            n_run++;
            if (ctl !== 8'h00) begin n_fail++; $display("FAIL abort_ctl c=%0d: got %b want %b", c, ctl, 8'h00); end
            n_run++;
            if (ar !== 45'd1) begin n_fail++; $display("FAIL abort_ar c=%0d: got %h want %h", c, ar, 45'd1); end
            next_cycle();
         end
      end else begin
         ax.rvalid = 1'b0;
         @(negedge clk);
         n_run++;
         if (ctl !== 8'h00) begin n_fail++; $display("FAIL end_idle_ctl: got %b want %b", ctl, 8'h00); end
         next_cycle();
      end
      ax.rvalid = 1'b0;
   endtask

   task automatic test_inst_basic();
      i_addr = 32'h1FC0_0000; i_len = 4'd3;
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 0);
   endtask

   task automatic test_tie();
      run_txn(1'b1, 1'b1, 1'b1, 1'b0, 0, 3, 0);
      run_txn(1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 0);
   endtask

   task automatic test_ar_stall();
      run_txn(1'b0, 1'b1, 1'b1, 1'b0, 5, 2, 0);
   endtask

   task automatic test_random();
      int r;
      for (int t = 0; t < 30; t++) begin
         if (i_req || d_req) run_txn(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(1, 4), 0);
         else begin
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], 1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(1, 4), 0);
         end
      end
      while (i_req || d_req) run_txn(1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0);
   endtask

   task automatic test_reset_mid();
      run_txn(1'b0, 1'b1, 1'b1, 1'b0, 0, 4, 2);
      run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 0);
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
      i_addr = '0; i_len = '0; d_addr = '0; d_len = '0; d_size = '0;
      ax.arready = 1'b0; ax.rid = '0; ax.rdata = '0; ax.rresp = '0; ax.rlast = 1'b0; ax.rvalid = 1'b0;
      m_last_d = 1'b0;
      test_reset();
      test_inst_basic();
      test_tie();
      test_ar_stall();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
